// File: rtl/uart_link.sv
// UART transmitter and receiver sharing one clock, CLK_DIV cycles per bit, 8 data bits, 1 stop bit.
// Define UART_PARITY_EN to insert and check an even-parity bit between the data bits and the stop bit.
module uart_link #(
    parameter int CLK_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic       UART_TX,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic [7:0] RX_DATA,
    output logic       RX_EFF,
    input  logic       RX_READ,
    output logic       RX_OVR,
    output logic       RX_ERR
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {T_IDLE = 3'd0, T_START = 3'd1, T_DATA = 3'd2, T_PAR = 3'd3, T_STOP = 3'd4} tx_state_t;
    typedef enum logic [2:0] {R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_PAR = 3'd3, R_STOP = 3'd4} rx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {T_IDLE = 3'd0, T_START = 3'd1, T_DATA = 3'd2, T_STOP = 3'd4} tx_state_t;
    typedef enum logic [2:0] {R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_STOP = 3'd4} rx_state_t;
`endif

    tx_state_t       tx_state_r;
    logic [CW-1:0]   tx_cnt_r;
    logic [2:0]      tx_bit_r;
    logic [7:0]      tx_shift_r;

    rx_state_t       rx_state_r;
    logic [CW-1:0]   rx_cnt_r;
    logic [2:0]      rx_bit_r;
    logic [7:0]      rx_shift_r;
    logic            rx_meta_r;
    logic            rx_sync_r;
    logic            rx_prev_r;
    logic            done_ok_r;
    logic            done_bad_r;
    logic            rx_fall_s;
`ifdef UART_PARITY_EN
    logic            par_bad_r;
`endif

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;

    // Transmit FSM; UART_TX and TX_STATUS are registered so each bit holds for CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= T_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            UART_TX    <= 1'b1;
            TX_STATUS  <= 1'b1;
        end else begin
            case (tx_state_r)
                T_IDLE: begin
                    if (TX_EN) begin
                        tx_shift_r <= TX_DATA;
                        tx_cnt_r   <= '0;
                        tx_bit_r   <= 3'd0;
                        UART_TX    <= 1'b0;
                        TX_STATUS  <= 1'b0;
                        tx_state_r <= T_START;
                    end
                end
                T_START: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r   <= '0;
                        UART_TX    <= tx_shift_r[0];
                        tx_state_r <= T_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                T_DATA: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                            UART_TX    <= even_parity(tx_shift_r);
                            tx_state_r <= T_PAR;
`else
                            UART_TX    <= 1'b1;
                            tx_state_r <= T_STOP;
`endif
                        end else begin
                            tx_bit_r <= tx_bit_r + 3'd1;
                            UART_TX  <= tx_shift_r[tx_bit_r + 3'd1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                T_PAR: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r   <= '0;
                        UART_TX    <= 1'b1;
                        tx_state_r <= T_STOP;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
`endif
                T_STOP: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r   <= '0;
                        UART_TX    <= 1'b1;
                        TX_STATUS  <= 1'b1;
                        tx_state_r <= T_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_cnt_r   <= '0;
                    UART_TX    <= 1'b1;
                    TX_STATUS  <= 1'b1;
                    tx_state_r <= T_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchronizer plus one history flop for start-edge detection; all idle high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM: half-bit resample of the start bit, then one mid-bit sample every CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= R_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            done_ok_r  <= 1'b0;
            done_bad_r <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_r  <= 1'b0;
`endif
        end else begin
            done_ok_r  <= 1'b0;
            done_bad_r <= 1'b0;
            case (rx_state_r)
                R_IDLE: begin
                    if (rx_fall_s) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                R_DATA: begin
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state_r <= R_PAR;
`else
                            rx_state_r <= R_STOP;
`endif
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                R_PAR: begin
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= '0;
                        par_bad_r  <= rx_sync_r ^ even_parity(rx_shift_r);
                        rx_state_r <= R_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
`endif
                R_STOP: begin
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= R_IDLE;
`ifdef UART_PARITY_EN
                        done_ok_r  <= rx_sync_r & ~par_bad_r;
                        done_bad_r <= ~rx_sync_r | par_bad_r;
`else
                        done_ok_r  <= rx_sync_r;
                        done_bad_r <= ~rx_sync_r;
`endif
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    rx_cnt_r   <= '0;
                    rx_state_r <= R_IDLE;
                end
            endcase
        end
    end

    // Host-facing receive status; a completing byte takes priority over a same-cycle read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RX_DATA <= 8'h00;
            RX_EFF  <= 1'b0;
            RX_OVR  <= 1'b0;
            RX_ERR  <= 1'b0;
        end else if (done_ok_r) begin
            RX_DATA <= rx_shift_r;
            RX_EFF  <= 1'b1;
            RX_OVR  <= RX_EFF ? ~RX_READ : RX_OVR;
            RX_ERR  <= (RX_EFF && RX_READ) ? 1'b0 : RX_ERR;
        end else if (done_bad_r) begin
            RX_ERR <= 1'b1;
            if (RX_EFF && RX_READ) begin
                RX_EFF <= 1'b0;
                RX_OVR <= 1'b0;
            end
        end else if (RX_EFF && RX_READ) begin
            RX_EFF <= 1'b0;
            RX_OVR <= 1'b0;
            RX_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_link.sv
// Self-checking bench for uart_link at CLK_DIV=16: cycle-level transmit model, frame-level receive model.
module tb_uart_link;

    localparam int D = 16;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       UART_RX = 1'b1;
    logic       UART_TX;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_EN = 1'b0;
    logic       TX_STATUS;
    logic [7:0] RX_DATA;
    logic       RX_EFF;
    logic       RX_READ = 1'b0;
    logic       RX_OVR;
    logic       RX_ERR;

    int total = 0;
    int bad = 0;

    uart_link #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .UART_RX(UART_RX), .UART_TX(UART_TX),
        .TX_DATA(TX_DATA), .TX_EN(TX_EN), .TX_STATUS(TX_STATUS),
        .RX_DATA(RX_DATA), .RX_EFF(RX_EFF), .RX_READ(RX_READ),
        .RX_OVR(RX_OVR), .RX_ERR(RX_ERR)
    );

    always #5 clk = ~clk;

    // transmit model: queue of {line, status} values, one per cycle of a frame
    logic [1:0] txq[$];
    logic       exp_tx = 1'b1;
    logic       exp_st = 1'b1;
    // receive model: what the host should see once a frame has ended
    logic [7:0] m_data = 8'h00;
    logic       m_eff = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_err = 1'b0;
    logic       rx_chk = 1'b1;
    logic       chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        logic [NB-1:0] fb;
        logic [1:0] e;
        if (!reset) begin
            txq.delete();
            exp_tx = 1'b1;
            exp_st = 1'b1;
        end else if (txq.size() > 0) begin
            e = txq.pop_front();
            exp_tx = e[1];
            exp_st = e[0];
        end else if (exp_st && TX_EN) begin
            fb = '0;
            fb[8:1] = TX_DATA;
`ifdef UART_PARITY_EN
            fb[9] = ^TX_DATA;
`endif
            fb[NB-1] = 1'b1;
            for (int i = 0; i < NB; i++)
                for (int j = 0; j < D; j++)
                    txq.push_back({fb[i], 1'b0});
            e = txq.pop_front();
            exp_tx = e[1];
            exp_st = e[0];
        end else begin
            exp_tx = 1'b1;
            exp_st = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_tx", UART_TX, exp_tx);
            check("tx_status", TX_STATUS, exp_st);
            if (rx_chk) begin
                check("rx_data", RX_DATA, m_data);
                check("rx_eff", RX_EFF, m_eff);
                check("rx_ovr", RX_OVR, m_ovr);
                check("rx_err", RX_ERR, m_err);
            end
        end
    end

    task automatic drive_bit(input logic v);
        UART_RX = v;
        repeat (D) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_stop, input logic bad_par);
        @(negedge clk);
        rx_chk = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit(^b ^ bad_par);
`endif
        drive_bit(~bad_stop);
        UART_RX = 1'b1;
`ifdef UART_PARITY_EN
        if (!bad_stop && !bad_par) begin
`else
        if (!bad_stop) begin
`endif
            if (m_eff) m_ovr = 1'b1;
            m_data = b;
            m_eff = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        #1 rx_chk = 1'b1;
    endtask

    task automatic glitch();
        @(negedge clk);
        UART_RX = 1'b0;
        repeat (4) @(negedge clk);
        UART_RX = 1'b1;
        repeat (D) @(negedge clk);
    endtask

    task automatic rx_read();
        @(negedge clk);
        RX_READ = 1'b1;
        @(posedge clk);
        if (m_eff) begin
            m_eff = 1'b0;
            m_ovr = 1'b0;
            m_err = 1'b0;
        end
        #1 RX_READ = 1'b0;
    endtask

    task automatic wait_tx_idle();
        @(negedge clk);
        for (int w = 0; w < 400 && TX_STATUS !== 1'b1; w++) @(negedge clk);
        check("tx_idle_wait", TX_STATUS, 1'b1);
    endtask

    task automatic tx_literal(input logic [7:0] b, input logic [10:0] want);
        int low;
        logic [10:0] got;
        low = 0;
        got = '0;
        wait_tx_idle();
        TX_DATA = b;
        TX_EN = 1'b1;
        @(negedge clk);
        TX_EN = 1'b0;
        for (int c = 0; c < NB * D + 20; c++) begin
            if ((c % D) == D / 2 && (c / D) < NB) got[c / D] = UART_TX;
            if (TX_STATUS == 1'b0) low++;
            @(negedge clk);
        end
        check("tx_frame_bits", got, want);
        check("tx_busy_cycles", low, NB * D);
    endtask

    task automatic tx_random(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int w = 0; w < 400 && TX_STATUS !== 1'b1; w++) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
            TX_DATA = 8'($urandom_range(0, 255));
            TX_EN = 1'b1;
            @(negedge clk);
            TX_EN = 1'b0;
        end
        repeat (NB * D + 10) @(negedge clk);
    endtask

    task automatic rx_random(input int n);
        int kind;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) glitch();
            else if (kind == 1) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
`ifdef UART_PARITY_EN
            else if (kind == 2) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
`endif
            else send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            repeat ($urandom_range(2, 12)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) rx_read();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_uart_tx", UART_TX, 1'b1);
        check("reset_tx_status", TX_STATUS, 1'b1);
        check("reset_rx_data", RX_DATA, 8'h00);
        check("reset_rx_flags", {RX_EFF, RX_OVR, RX_ERR}, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

`ifdef UART_PARITY_EN
        tx_literal(8'hA5, 11'b10100101010);
`else
        tx_literal(8'hA5, 11'b01101001010);
`endif

        send_frame(8'h3C, 1'b0, 1'b0);
        check("rx_3c_data", RX_DATA, 8'h3C);
        check("rx_3c_eff", RX_EFF, 1'b1);
        rx_read();
        @(negedge clk);
        check("read_clears_eff", RX_EFF, 1'b0);

        glitch();
        check("glitch_state", {RX_EFF, RX_ERR, RX_DATA}, {2'b00, 8'h3C});

        send_frame(8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send_frame(8'h22, 1'b0, 1'b0);
        check("overrun_data", RX_DATA, 8'h22);
        check("overrun_flag", RX_OVR, 1'b1);
        repeat (3) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b0);
        check("frame_err_flag", RX_ERR, 1'b1);
        check("frame_err_keeps_data", RX_DATA, 8'h22);

`ifdef UART_PARITY_EN
        rx_read();
        repeat (2) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("parity_err_flag", RX_ERR, 1'b1);
        check("parity_err_eff", RX_EFF, 1'b0);
        tx_literal(8'h07, 11'b11000001110);
`endif

        // reset during data bit 3 of a transmit, with a receive frame half-delivered
        wait_tx_idle();
        TX_DATA = 8'h5A;
        TX_EN = 1'b1;
        UART_RX = 1'b0;
        @(negedge clk);
        TX_EN = 1'b0;
        repeat (70) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        m_data = 8'h00;
        m_eff = 1'b0;
        m_ovr = 1'b0;
        m_err = 1'b0;
        #1;
        check("midframe_reset_uart_tx", UART_TX, 1'b1);
        check("midframe_reset_tx_status", TX_STATUS, 1'b1);
        check("midframe_reset_rx_data", RX_DATA, 8'h00);
        UART_RX = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12 * D) @(negedge clk);
        check("no_partial_byte", {RX_EFF, RX_ERR}, 2'b00);
`ifdef UART_PARITY_EN
        tx_literal(8'h0F, 11'b10000011110);
`else
        tx_literal(8'h0F, 11'b01000011110);
`endif

        fork
            tx_random(40);
            rx_random(40);
        join
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 Parameter CLK_DIV SHALL default to 5208 and give the clock cycles per serial bit; legal values are 4 or more.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the single rising-edge clock.
REQ-003 Port reset SHALL be an input, 1 bit wide, and be an asynchronous active-low reset.
REQ-004 Port UART_RX SHALL be an input, 1 bit wide, and carry the serial receive line, which idles high.
REQ-005 Port UART_TX SHALL be an output, 1 bit wide, and drive the serial transmit line, which idles high.
REQ-006 Port TX_DATA SHALL be an input, 8 bits wide, and carry the byte the core wants to send.
REQ-007 Port TX_EN SHALL be an input, 1 bit wide, and be a one-cycle send request.
REQ-008 Port TX_STATUS SHALL be an output, 1 bit wide: 1 means the transmitter is idle and accepts TX_EN.
REQ-009 Port RX_DATA SHALL be an output, 8 bits wide, and hold the last received byte.
REQ-010 Port RX_EFF SHALL be an output, 1 bit wide: 1 means RX_DATA holds an unread byte.
REQ-011 Port RX_READ SHALL be an input, 1 bit wide, and be a one-cycle acknowledge that the core consumed RX_DATA.
REQ-012 Port RX_OVR SHALL be an output, 1 bit wide, and be a sticky overrun flag.
REQ-013 Port RX_ERR SHALL be an output, 1 bit wide, and be a sticky frame or parity error flag.

Function
REQ-014 Transmit FSM states SHALL be IDLE, START, DATA, (PARITY), STOP, and every state except IDLE SHALL last exactly CLK_DIV cycles.
REQ-015 TX_EN sampled high in IDLE SHALL latch TX_DATA, drive TX_STATUS low on the next cycle, and start the start bit (UART_TX=0) on that same cycle.
REQ-016 TX_EN while TX_STATUS=0 SHALL be ignored, with no queueing.
REQ-017 Data bits SHALL be sent LSB first, followed by one stop bit (1).
REQ-018 TX_STATUS SHALL return to 1 on the cycle after the stop bit's final cycle.
REQ-019 TX_EN on that same cycle SHALL be accepted, allowing back-to-back frames.
REQ-020 UART_RX SHALL pass through a 2-flop synchronizer before use, and all receive timing SHALL be measured on the synchronized signal.
REQ-021 The receive FSM SHALL detect a falling edge in IDLE, wait CLK_DIV/2 cycles, and resample the line.
REQ-022 If that resample is high, the receiver SHALL treat it as a false start, return to IDLE, and report nothing.
REQ-023 After a valid start, the receiver SHALL sample the 8 data bits, LSB first, then the stop bit, each CLK_DIV cycles apart at mid-bit.
REQ-024 A stop sample of 1 SHALL, one cycle later, load RX_DATA and set RX_EFF.
REQ-025 A stop sample of 0 SHALL discard the byte, leave RX_DATA and RX_EFF unchanged, and set RX_ERR.
REQ-026 RX_READ while RX_EFF=1 SHALL clear RX_EFF, RX_OVR and RX_ERR on the next cycle; RX_READ while RX_EFF=0 SHALL have no effect.
REQ-027 If a byte completes while RX_EFF=1 and RX_READ is absent, RX_DATA SHALL be overwritten with the new byte and RX_OVR set to 1.
REQ-028 If a byte completes in the same cycle as RX_READ, the new byte SHALL win: RX_EFF stays 1, RX_DATA is updated, and RX_OVR is cleared.
REQ-029 Transmitter and receiver SHALL be fully independent, with simultaneous operation allowed.

Reset
REQ-030 reset low SHALL take effect immediately, without waiting for clk: both FSMs go to IDLE, UART_TX=1, TX_STATUS=1, RX_DATA=0x00, RX_EFF=0, RX_OVR=0, RX_ERR=0, synchronizer flops=1, and bit counters=0.
REQ-031 Reset mid-frame SHALL abandon the frame, and no partial byte SHALL be reported after reset is released.

Configuration
REQ-032 With macro UART_PARITY_EN defined, an even-parity bit SHALL be inserted between the data bits and the stop bit on transmit, and checked on receive.
REQ-033 With UART_PARITY_EN defined, a parity mismatch SHALL discard the byte and set RX_ERR, exactly as a framing error does.
REQ-034 Without UART_PARITY_EN, frames SHALL be 10 bits (start, 8 data, stop), and no PARITY state or parity logic SHALL exist.

Verification (CLK_DIV=16)
REQ-035 TX_EN with TX_DATA=0xA5 -> UART_TX shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; TX_STATUS is low for exactly 160 cycles.
REQ-036 Serial 0x3C driven on UART_RX -> RX_EFF=1 and RX_DATA=0x3C; a subsequent RX_READ pulse -> RX_EFF=0 one cycle later.
REQ-037 A 4-cycle low glitch on UART_RX -> RX_EFF, RX_ERR and RX_DATA are unchanged.
REQ-038 Bytes 0x11 then 0x22 received with no RX_READ -> RX_DATA=0x22, RX_OVR=1; a stop bit forced to 0 on a third frame -> RX_ERR=1 and RX_DATA stays 0x22.
REQ-039 reset asserted during the 4th data bit of a transmit -> UART_TX=1 and TX_STATUS=1 before the next clk edge; a later TX_EN sends a clean frame.
REQ-040 With UART_PARITY_EN, TX_DATA=0x07 -> parity bit 1 and an 11-bit frame (176 cycles); an RX frame with a flipped parity bit -> RX_ERR=1 and RX_EFF stays 0.
